// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the iterative multiply/divide unit.
//  - operation codes presented on mult_div_unit.op
//  - FSM state encoding used by the top level
//  - iteration counter width helper: $clog2(n_bits)+1
package mdu_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_e;

    // Counter must reach n_bits itself, hence the extra bit.
    function automatic int mdu_cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// mdu_iter_core: purely combinational single iteration of the MDU datapath.
//  Multiply (is_div=0): acc = {partial_hi, multiplier}; add opnd to the upper half
//   when the multiplier LSB is set, then shift the whole accumulator right by one.
//  Divide (is_div=1): acc = {remainder, dividend/quotient}; shift left by one,
//   trial-subtract opnd from the widened remainder and shift in the quotient bit.
// Ports:
//  is_div  in   1          selects the divide step
//  acc_i   in   2*n_bits   current accumulator
//  opnd    in   n_bits     multiplicand (multiply) or divisor (divide) magnitude
//  acc_o   out  2*n_bits   accumulator after one step
module mdu_iter_core #(
    parameter int n_bits = 32
) (
    input  logic                  is_div,
    input  logic [2*n_bits-1:0]   acc_i,
    input  logic [n_bits-1:0]     opnd,
    output logic [2*n_bits-1:0]   acc_o
);

    logic [n_bits:0]   sum;
    logic [n_bits:0]   upper_next;
    logic [n_bits:0]   r_sh;
    logic              ge;
    logic [n_bits-1:0] r_next;

    // One shift-add or restoring-subtract step
    always_comb begin
        sum        = {1'b0, acc_i[2*n_bits-1:n_bits]} + {1'b0, opnd};
        upper_next = acc_i[0] ? sum : {1'b0, acc_i[2*n_bits-1:n_bits]};
        // Remainder is always below the divisor, so the shifted value fits n_bits+1
        // bits and the difference (when taken) fits n_bits bits.
        r_sh       = acc_i[2*n_bits-1:n_bits-1];
        ge         = (r_sh >= {1'b0, opnd});
        r_next     = ge ? (r_sh[n_bits-1:0] - opnd) : r_sh[n_bits-1:0];
        if (is_div) begin
            acc_o = {r_next, acc_i[n_bits-2:0], ge};
        end else begin
            acc_o = {upper_next, acc_i[n_bits-1:1]};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU with architectural HI/LO registers,
// plus single-cycle MTHI/MTLO. Multiply/divide take n_bits step edges after the
// start edge; done pulses for one cycle when hi/lo hold the new result.
// Optional feature macro: MDU_SIGNED_EN -- when defined, MULT/DIV are signed
// (magnitudes at start, sign fix-up on the final edge); otherwise they behave as
// MULTU/DIVU.
// Ports:
//  clk, rst_n   clock, asynchronous active-low reset
//  start, op    request and op code (sampled only when not busy)
//  src_a/src_b  operands from the register file
//  busy         iteration in progress (stall)
//  done         one-cycle result pulse
//  div_by_zero  pulses with done on a divide with src_b==0
//  hi, lo       HI/LO registers
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int n_bits = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [n_bits-1:0] src_a,
    input  logic [n_bits-1:0] src_b,
    output logic              busy,
    output logic              done,
    output logic              div_by_zero,
    output logic [n_bits-1:0] hi,
    output logic [n_bits-1:0] lo
);

    localparam int               CNT_W     = mdu_cnt_width(n_bits);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(n_bits - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    mdu_state_e          state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [2*n_bits-1:0] acc_q, acc_d, step_acc, res;
    logic [n_bits-1:0]   opnd_q, opnd_d, hi_q, hi_d, lo_q, lo_d;
    logic [n_bits-1:0]   mag_a, mag_b;
    logic                is_div_q, is_div_d, dbz_pend_q, dbz_pend_d;
    logic                busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
    logic                op_is_div;

    assign op_is_div = (op == OP_DIV) || (op == OP_DIVU);

    mdu_iter_core #(.n_bits(n_bits)) u_core (
        .is_div (is_div_q),
        .acc_i  (acc_q),
        .opnd   (opnd_q),
        .acc_o  (step_acc)
    );

`ifdef MDU_SIGNED_EN
    logic sgn_op, neg_lo_start, neg_hi_start;
    logic neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;

    // Operand magnitudes and result signs for a signed request
    always_comb begin
        sgn_op       = (op == OP_MULT) || (op == OP_DIV);
        mag_a        = (sgn_op && src_a[n_bits-1]) ? -src_a : src_a;
        mag_b        = (sgn_op && src_b[n_bits-1]) ? -src_b : src_b;
        // neg_lo: product sign (multiply) or quotient sign (divide)
        neg_lo_start = sgn_op && (src_a[n_bits-1] ^ src_b[n_bits-1]);
        // neg_hi: remainder follows the dividend sign
        neg_hi_start = sgn_op && src_a[n_bits-1];
    end

    // Sign fix-up of the final step; a zero divisor keeps the raw all-ones quotient
    always_comb begin
        res = step_acc;
        if (is_div_q) begin
            res[2*n_bits-1:n_bits] = neg_hi_q ? -step_acc[2*n_bits-1:n_bits]
                                              : step_acc[2*n_bits-1:n_bits];
            res[n_bits-1:0]        = (neg_lo_q && !dbz_pend_q) ? -step_acc[n_bits-1:0]
                                                               : step_acc[n_bits-1:0];
        end else begin
            res = neg_lo_q ? -step_acc : step_acc;
        end
    end
`else
    assign mag_a = src_a;
    assign mag_b = src_b;
    assign res   = step_acc;
`endif

    // Next-state, datapath and registered-output logic
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        is_div_d   = is_div_q;
        dbz_pend_d = dbz_pend_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        dbz_d      = 1'b0;
`ifdef MDU_SIGNED_EN
        neg_lo_d   = neg_lo_q;
        neg_hi_d   = neg_hi_q;
`endif
        case (state_q)
            // DONE accepts a new request exactly like IDLE
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            state_d    = ST_RUN;
                            busy_d     = 1'b1;
                            count_d    = '0;
                            is_div_d   = op_is_div;
                            dbz_pend_d = op_is_div && (src_b == '0);
                            acc_d      = {{n_bits{1'b0}}, (op_is_div ? mag_a : mag_b)};
                            opnd_d     = op_is_div ? mag_b : mag_a;
`ifdef MDU_SIGNED_EN
                            neg_lo_d   = neg_lo_start;
                            neg_hi_d   = neg_hi_start;
`endif
                        end
                        OP_MTHI: hi_d = src_a;
                        OP_MTLO: lo_d = src_a;
                        default: state_d = ST_IDLE;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                acc_d   = step_acc;
                count_d = count_q + CNT_ONE;
                if (count_q == LAST_STEP) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    dbz_d   = dbz_pend_q;
                    hi_d    = res[2*n_bits-1:n_bits];
                    lo_d    = res[n_bits-1:0];
                end else begin
                    busy_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            is_div_q   <= 1'b0;
            dbz_pend_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
`ifdef MDU_SIGNED_EN
            neg_lo_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            is_div_q   <= is_div_d;
            dbz_pend_q <= dbz_pend_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            dbz_q      <= dbz_d;
`ifdef MDU_SIGNED_EN
            neg_lo_q   <= neg_lo_d;
            neg_hi_q   <= neg_hi_d;
`endif
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule
